// File: rtl/shift_sel_concat_pipe.sv
// Pipelined shift / select / concatenate unit with valid/ready flow control.
// Results are computed at entry and carried through PIPE register stages.
module shift_sel_concat_pipe #(
    parameter int WIDTH = 16,
    parameter int PIPE  = 2,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW:0]     in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       out_op,
    output logic             out_sat,
    output logic [15:0]      out_count
);

    // Handshake: a beat moves on a rising edge where valid and ready are both 1.
    // The whole pipe advances together (en), so in_ready is simply en and a
    // stalled output freezes every stage, bubbles included.

    localparam int H = WIDTH / 2;

    localparam logic [2:0] OP_SLL   = 3'd0;
    localparam logic [2:0] OP_SRL   = 3'd1;
    localparam logic [2:0] OP_SRA   = 3'd2;
    localparam logic [2:0] OP_ROL   = 3'd3;
    localparam logic [2:0] OP_SEL   = 3'd4;
    localparam logic [2:0] OP_SWAP  = 3'd5;
    localparam logic [2:0] OP_NSWAP = 3'd6;
    localparam logic [2:0] OP_REPL  = 3'd7;

    localparam logic [SHW:0]   W_AMT   = (SHW+1)'(WIDTH);
    localparam logic [SHW+1:0] H_EXT   = (SHW+2)'(H);
    localparam logic [SHW+1:0] W_EXT   = (SHW+2)'(WIDTH);

    logic                 en;
    logic                 amt_big;
    logic [SHW:0]         rot_amt;
    logic [2*WIDTH-1:0]   rot_tmp;
    logic [2*WIDTH-1:0]   sel_tmp;
    logic [SHW+1:0]       sel_end;
    logic [WIDTH-1:0]     swap_val;
    logic [WIDTH-1:0]     res_data;
    logic                 res_sat;

    logic [PIPE-1:0]      stg_valid;
    logic [PIPE-1:0]      stg_sat;
    logic [WIDTH-1:0]     stg_data [PIPE];
    logic [2:0]           stg_op   [PIPE];
    logic [15:0]          count_q;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // Entry datapath: every op is evaluated, the op code picks one.
    always_comb begin
        amt_big  = (in_amt >= W_AMT);
        rot_amt  = amt_big ? (in_amt - W_AMT) : in_amt;
        rot_tmp  = {in_data, in_data} << rot_amt;
        sel_tmp  = {{WIDTH{1'b0}}, in_data} >> in_amt;
        sel_end  = {1'b0, in_amt} + H_EXT;
        swap_val = {in_data[H-1:0], in_data[WIDTH-1:H]};
        res_data = '0;
        res_sat  = 1'b0;
        case (in_op)
            OP_SLL: begin
                res_data = amt_big ? '0 : (in_data << in_amt);
                res_sat  = amt_big;
            end
            OP_SRL: begin
                res_data = amt_big ? '0 : (in_data >> in_amt);
                res_sat  = amt_big;
            end
            OP_SRA: begin
                res_data = amt_big ? {WIDTH{in_data[WIDTH-1]}}
                                   : WIDTH'($signed(in_data) >>> in_amt);
                res_sat  = amt_big;
            end
            OP_ROL: begin
                res_data = rot_tmp[2*WIDTH-1:WIDTH];
            end
            OP_SEL: begin
                res_data = {{(WIDTH-H){1'b0}}, sel_tmp[H-1:0]};
                res_sat  = (sel_end > W_EXT);
            end
            OP_SWAP:  res_data = swap_val;
            OP_NSWAP: res_data = ~swap_val;
            OP_REPL:  res_data = {2{in_data[H-1:0]}};
            default: begin
                res_data = '0;
                res_sat  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid <= '0;
            stg_sat   <= '0;
            for (int i = 0; i < PIPE; i++) begin
                stg_data[i] <= '0;
                stg_op[i]   <= '0;
            end
        end else if (en) begin
            stg_valid[0] <= in_valid;
            stg_sat[0]   <= res_sat;
            stg_data[0]  <= res_data;
            stg_op[0]    <= in_op;
            for (int i = 1; i < PIPE; i++) begin
                stg_valid[i] <= stg_valid[i-1];
                stg_sat[i]   <= stg_sat[i-1];
                stg_data[i]  <= stg_data[i-1];
                stg_op[i]    <= stg_op[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (out_valid && out_ready) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign out_valid = stg_valid[PIPE-1];
    assign out_data  = stg_data[PIPE-1];
    assign out_op    = stg_op[PIPE-1];
    assign out_sat   = stg_sat[PIPE-1];
    assign out_count = count_q;

endmodule

// File: tb/tb_shift_sel_concat_pipe.sv
// Self-checking bench for shift_sel_concat_pipe: directed vector table,
// multi-cycle corner sequences and a randomized backpressure run.
module tb_shift_sel_concat_pipe;

    localparam int WIDTH = 16;
    localparam int PIPE  = 2;
    localparam int SHW   = 4;
    localparam int H     = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_data;
    logic [SHW:0]     in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       out_op;
    logic             out_sat;
    logic [15:0]      out_count;

    shift_sel_concat_pipe #(.WIDTH(WIDTH), .PIPE(PIPE)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_data(in_data), .in_amt(in_amt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_op(out_op), .out_sat(out_sat), .out_count(out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] data;
        logic [4:0]  amt;
        logic [15:0] exp_d;
        logic        exp_s;
    } vec_t;

    vec_t        vecs [16];
    logic [19:0] exp_q [$];
    int          acc_q [$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_xfer = 0;
    bit          lat_chk = 1'b1;
    bit          b2b = 1'b0;
    int          b2b_n = 0;
    int          b2b_last = 0;
    int          b2b_gap = 0;
    logic [19:0] mon_e;
    int          mon_a;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model written bit by bit, independent of the RTL's shift operators.
    function automatic logic [16:0] model(input logic [2:0] op, input logic [15:0] d, input int amt);
        logic [15:0] r;
        logic        s;
        r = '0;
        s = 1'b0;
        case (op)
            3'd0: begin
                s = (amt >= 16);
                for (int i = 0; i < 16; i++) r[i] = (i - amt >= 0) ? d[i-amt] : 1'b0;
            end
            3'd1: begin
                s = (amt >= 16);
                for (int i = 0; i < 16; i++) r[i] = (i + amt < 16) ? d[i+amt] : 1'b0;
            end
            3'd2: begin
                s = (amt >= 16);
                for (int i = 0; i < 16; i++) r[i] = (i + amt < 16) ? d[i+amt] : d[15];
            end
            3'd3: for (int i = 0; i < 16; i++) r[i] = d[(i - (amt % 16) + 16) % 16];
            3'd4: begin
                s = (amt + H > 16);
                for (int i = 0; i < H; i++) r[i] = (amt + i < 16) ? d[amt+i] : 1'b0;
            end
            3'd5: r = {d[7:0], d[15:8]};
            3'd6: r = ~{d[7:0], d[15:8]};
            default: r = {d[7:0], d[7:0]};
        endcase
        return {r, s};
    endfunction

    task automatic send(input logic [2:0] op, input logic [15:0] d, input logic [4:0] amt,
                        input logic [15:0] ed, input logic es);
        int budget;
        in_op    = op;
        in_data  = d;
        in_amt   = amt;
        in_valid = 1'b1;
        budget   = 0;
        @(negedge clk);
        while (!in_ready && budget < 100) begin
            budget++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("send_timeout", 32'd0, 32'd1);
            @(posedge clk);
            #1 in_valid = 1'b0;
            return;
        end
        exp_q.push_back({op, ed, es});
        acc_q.push_back(cyc);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [2:0]  op;
        logic [15:0] d;
        logic [4:0]  amt;
        logic [16:0] m;
        op  = 3'($urandom_range(0, 7));
        d   = 16'($urandom_range(0, 65535));
        amt = 5'($urandom_range(0, 31));
        m   = model(op, d, int'(amt));
        send(op, d, amt, m[16:1], m[0]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        n_xfer = 0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 300) begin
            budget++;
            @(posedge clk);
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard on every completed transfer.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_a = acc_q.pop_front();
                check("out_data", 32'(out_data), 32'(mon_e[16:1]));
                check("out_sat", 32'(out_sat), 32'(mon_e[0]));
                check("out_op", 32'(out_op), 32'(mon_e[19:17]));
                if (lat_chk) check("latency", 32'(cyc - mon_a), 32'(PIPE));
                if (b2b) begin
                    if (b2b_n > 0 && cyc != b2b_last + 1) b2b_gap++;
                    b2b_last = cyc;
                    b2b_n++;
                end
            end
        end
    end

    initial begin
        logic [16:0] m0;
        bit          rnd_done;

        vecs[0]  = '{3'd0, 16'h00F1, 5'd4,  16'h0F10, 1'b0};
        vecs[1]  = '{3'd0, 16'hFFFF, 5'd16, 16'h0000, 1'b1};
        vecs[2]  = '{3'd0, 16'h0001, 5'd15, 16'h8000, 1'b0};
        vecs[3]  = '{3'd1, 16'h8000, 5'd15, 16'h0001, 1'b0};
        vecs[4]  = '{3'd1, 16'hFFFF, 5'd16, 16'h0000, 1'b1};
        vecs[5]  = '{3'd2, 16'h8001, 5'd3,  16'hF000, 1'b0};
        vecs[6]  = '{3'd2, 16'h8001, 5'd20, 16'hFFFF, 1'b1};
        vecs[7]  = '{3'd2, 16'h7FFF, 5'd20, 16'h0000, 1'b1};
        vecs[8]  = '{3'd3, 16'h8001, 5'd1,  16'h0003, 1'b0};
        vecs[9]  = '{3'd3, 16'h8001, 5'd17, 16'h0003, 1'b0};
        vecs[10] = '{3'd4, 16'hABCD, 5'd4,  16'h00BC, 1'b0};
        vecs[11] = '{3'd4, 16'hABCD, 5'd12, 16'h000A, 1'b1};
        vecs[12] = '{3'd4, 16'hABCD, 5'd31, 16'h0000, 1'b1};
        vecs[13] = '{3'd4, 16'hABCD, 5'd8,  16'h00AB, 1'b0};
        vecs[14] = '{3'd5, 16'h1234, 5'd0,  16'h3412, 1'b0};
        vecs[15] = '{3'd6, 16'h1234, 5'd9,  16'hCBED, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_data   = '0;
        in_amt    = '0;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed vectors, including REPL as a hand-written entry.
        for (int i = 0; i < 16; i++)
            send(vecs[i].op, vecs[i].data, vecs[i].amt, vecs[i].exp_d, vecs[i].exp_s);
        send(3'd7, 16'h1234, 5'd3, 16'h3434, 1'b0);
        drain();
        check("table_count", 32'(out_count), 32'd17);

        // Back-to-back at full rate.
        do_reset();
        b2b = 1'b1;
        for (int i = 0; i < 8; i++) send_rand();
        drain();
        b2b = 1'b0;
        check("b2b_results", 32'(b2b_n), 32'd8);
        check("b2b_gaps", 32'(b2b_gap), 32'd0);
        check("b2b_count", 32'(out_count), 32'd8);

        // Backpressure: 4 beats offered while the consumer stalls.
        do_reset();
        lat_chk   = 1'b0;
        out_ready = 1'b0;
        m0 = model(3'd7, 16'h1111, 0);
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    logic [16:0] mk;
                    mk = model(3'(7 - k), 16'(16'h1111 * (k + 1)), k);
                    send(3'(7 - k), 16'(16'h1111 * (k + 1)), 5'(k), mk[16:1], mk[0]);
                end
            end
            begin
                repeat (4) begin
                    @(negedge clk);
                    if (out_valid) begin
                        check("stall_in_ready", 32'(in_ready), 32'd0);
                        check("stall_data", 32'(out_data), 32'(m0[16:1]));
                        check("stall_sat", 32'(out_sat), 32'(m0[0]));
                    end
                end
                check("stall_valid", 32'(out_valid), 32'd1);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 32'(out_count), 32'd4);

        // Randomized ops with random consumer backpressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) send_rand();
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("rand_count", 32'(out_count), 32'(n_xfer));

        // Reset with two beats in flight.
        lat_chk = 1'b1;
        send(3'd5, 16'hA5C3, 5'd0, 16'hC3A5, 1'b0);
        send(3'd7, 16'h00FF, 5'd0, 16'hFFFF, 1'b0);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_count", 32'(out_count), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        acc_q.delete();
        n_xfer = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        send(3'd1, 16'hF000, 5'd4, 16'h0F00, 1'b0);
        drain();
        check("post_rst_count", 32'(out_count), 32'd1);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_sel_concat_pipe.md
# shift_sel_concat_pipe

Parametrised, pipelined shift/select/concatenate unit. Each accepted beat carries one operation: logical or arithmetic shift, rotate, field extract, half-swap, inverted half-swap or half-replicate. The result returns PIPE cycles later over a valid/ready handshake. It is the sequential successor to the combinational shift/select/concat datapath, sits between an operand source and a result consumer, and adds backpressure, saturation flagging and a transfer counter.

## Interface
- WIDTH, 16, data width; even, >= 4
- PIPE, 2, pipeline depth in register stages; 1..4
- SHW, $clog2(WIDTH), derived; not overridden
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit accepts beat this cycle
- in_op  in  3  operation code (see Operation)
- in_data  in  WIDTH  operand
- in_amt  in  SHW+1  shift/rotate amount or field LSB; range 0..2*WIDTH-1
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  result
- out_op  out  3  in_op of the beat, delayed with it
- out_sat  out  1  amount out of range for this op (see Operation)
- out_count  out  16  completed output transfers, wraps modulo 2^16

## Operation
- Ops (H = WIDTH/2):
  - 0 SLL: in_data << in_amt. Zeros shift in. in_amt >= WIDTH gives 0 and sat=1.
  - 1 SRL: in_data >> in_amt. Zeros shift in. in_amt >= WIDTH gives 0 and sat=1.
  - 2 SRA: arithmetic right shift; MSB fills. in_amt >= WIDTH gives all-MSB and sat=1.
  - 3 ROL: rotate left by in_amt mod WIDTH. sat=0.
  - 4 SEL: result[H-1:0] = in_data[in_amt +: H]; bits beyond in_data MSB read 0; result[WIDTH-1:H] = 0. sat=1 when in_amt + H > WIDTH.
  - 5 SWAP: {in_data[H-1:0], in_data[WIDTH-1:H]}. sat=0.
  - 6 NSWAP: bitwise NOT of SWAP. sat=0.
  - 7 REPL: {2{in_data[H-1:0]}}. sat=0.
- Result, sat and op are computed combinationally at entry and captured into stage 1. Stages 2..PIPE are pure delay registers, each holding a valid bit, data, op and sat.
- Global advance: en = ~out_valid | out_ready.
  - When en=1, every stage loads from the previous stage, and stage 1 loads from the input with valid = in_valid.
  - When en=0, all stages hold.
- in_ready = en. A beat transfers when in_valid & in_ready.
- Bubbles are not compacted. An invalid stage advances like a valid one.
- out_* is driven from the last stage. out_data, out_op and out_sat are meaningful only when out_valid=1.
- out_count increments by 1 on out_valid & out_ready and wraps 0xFFFF -> 0x0000.
- Ordering is strictly FIFO. No beat is dropped or duplicated.

## Timing
- Reset (async assert, released synchronously to clk): all stage valids 0, all data/op/sat registers 0, out_count 0. During reset in_ready=1 and out_valid=0.
- Latency: a beat accepted at edge N is presented with out_valid=1 after edge N+PIPE-1, i.e. PIPE register stages deep. With out_ready held 1, sustained throughput is one beat per cycle.
- Stall: when out_valid=1 & out_ready=0, in_ready=0 in the same cycle (combinational). out_data and out_sat stay stable until the transfer.
- Simultaneous out transfer and in accept in the same cycle is legal and required at full rate.
- Reset asserted mid-stream discards all in-flight beats immediately and clears out_count. The first beat after release sees full PIPE latency.
- in_amt values above 2*WIDTH-1 are not representable; all representable values are handled as defined above.

## Test plan
(WIDTH=16, PIPE=2)
- SLL 0x00F1 amt 4 -> 0x0F10, sat 0, PIPE cycles later. SLL amt 16 -> 0x0000, sat 1. SRL 0x8000 amt 15 -> 0x0001.
- SRA 0x8001 amt 3 -> 0xF000, sat 0. SRA 0x8001 amt 20 -> 0xFFFF, sat 1. ROL 0x8001 amt 1 -> 0x0003. ROL 0x8001 amt 17 -> 0x0003, sat 0.
- SEL 0xABCD amt 4 -> 0x00BC, sat 0. SEL 0xABCD amt 12 -> 0x000A, sat 1. SEL amt 31 -> 0x0000, sat 1.
- SWAP 0x1234 -> 0x3412. NSWAP 0x1234 -> 0xCBED. REPL 0x1234 -> 0x3434. out_op echoes 5, 6, 7 respectively.
- Back-to-back: 8 beats with in_valid=1 and out_ready=1 -> 8 results on consecutive cycles in order, out_count=8.
- Backpressure: out_ready=0 for 4 cycles while 4 beats are offered -> in_ready drops once out_valid=1. No loss or reorder. out_data is stable while stalled, and out_count=4 after drain.
- Reset mid-stream: assert rst with 2 beats in flight -> out_valid=0 and out_count=0 immediately. The next beat after release appears PIPE cycles after acceptance.
